// File: rtl/adpll_lock_sequencer.sv
// ADPLL lock sequencer: steps the loop filter through hold, cold acquisition,
// bandwidth transfer and tracking, and flags loss of lock.
module adpll_lock_sequencer #(
  parameter int ERR_W    = 27,
  parameter int HOLD_CYC = 16
) (
  input  logic                    ref_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [7:0]              upd_period,
  input  logic signed [ERR_W-1:0] error_in,
  input  logic [12:0]             freq_lock_thresh,
  input  logic [5:0]              lock_count_target,
  input  logic [12:0]             unlock_thresh,
  input  logic [3:0]              unlock_count,
  output logic                    reset2,
  output logic                    reset3,
  output logic                    cold_start_traditional,
  output logic                    lowbw_pre,
  output logic                    lowbw1,
  output logic                    fine_done_traditional,
  output logic                    locked,
  output logic                    lock_lost,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_COLD     = 3'd2,
    ST_TRANSFER = 3'd3,
    ST_TRACK    = 3'd4
  } state_e;

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [7:0]        upd_cnt_q, upd_cnt_d, upd_last;
  logic [5:0]        good_cnt_q, good_cnt_d, good_target;
  logic [3:0]        bad_cnt_q, bad_cnt_d, bad_target;
  logic              xfer_cnt_q, xfer_cnt_d;
  logic              lock_lost_q, lock_lost_d;
  logic              reset2_q, reset2_d;
  logic              cold_q, cold_d;
  logic              lowbw_pre_q, lowbw_pre_d;
  logic              lowbw1_q, lowbw1_d;
  logic              fine_done_q, fine_done_d;
  logic              locked_q, locked_d;
  logic [ERR_W-1:0]  err_abs;
  logic              err_good, err_bad;

  // The most negative error saturates so its magnitude still fits ERR_W bits.
  always_comb begin
    if (!error_in[ERR_W-1])
      err_abs = $unsigned(error_in);
    else if (error_in == {1'b1, {(ERR_W-1){1'b0}}})
      err_abs = {1'b0, {(ERR_W-1){1'b1}}};
    else
      err_abs = $unsigned(-error_in);
    err_good    = err_abs <= {{(ERR_W-13){1'b0}}, freq_lock_thresh};
    err_bad     = err_abs >  {{(ERR_W-13){1'b0}}, unlock_thresh};
    good_target = (lock_count_target == 6'd0) ? 6'd1 : lock_count_target;
    bad_target  = (unlock_count == 4'd0) ? 4'd1 : unlock_count;
    upd_last    = (upd_period <= 8'd1) ? 8'd0 : upd_period - 8'd1;
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      upd_cnt_q   <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      xfer_cnt_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      reset2_q    <= 1'b0;
      cold_q      <= 1'b0;
      lowbw_pre_q <= 1'b0;
      lowbw1_q    <= 1'b0;
      fine_done_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      lock_lost_q <= lock_lost_d;
      reset2_q    <= reset2_d;
      cold_q      <= cold_d;
      lowbw_pre_q <= lowbw_pre_d;
      lowbw1_q    <= lowbw1_d;
      fine_done_q <= fine_done_d;
      locked_q    <= locked_d;
    end
  end

  // Error decisions are taken on the edge that ends a strobe cycle.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_COLD;
        else hold_cnt_d = hold_cnt_q + HW'(1);
      end
      ST_COLD: begin
        if (fine_done_q) begin
          if (!err_good) good_cnt_d = 6'd0;
          else if (good_cnt_q != 6'd63) good_cnt_d = good_cnt_q + 6'd1;
          if (good_cnt_d >= good_target) state_d = ST_TRANSFER;
        end
      end
      ST_TRANSFER: begin
        if (fine_done_q) begin
          if (xfer_cnt_q) state_d = ST_TRACK;
          else xfer_cnt_d = 1'b1;
        end
      end
      ST_TRACK: begin
        if (fine_done_q) begin
          if (!err_bad) bad_cnt_d = 4'd0;
          else if (bad_cnt_q != 4'd15) bad_cnt_d = bad_cnt_q + 4'd1;
          if (bad_cnt_d >= bad_target) begin
            state_d     = ST_COLD;
            lock_lost_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      xfer_cnt_d = 1'b0;
    end
    if (state_q == ST_IDLE && state_d != ST_IDLE) lock_lost_d = 1'b0;
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    if (state_d == ST_IDLE || state_q == ST_IDLE ||
        (state_q == ST_HOLD && state_d == ST_COLD))
      upd_cnt_d = 8'd0;
    else if (upd_cnt_q >= upd_last)
      upd_cnt_d = 8'd0;
    else
      upd_cnt_d = upd_cnt_q + 8'd1;
    fine_done_d = (state_d != ST_IDLE) && (upd_cnt_d == upd_last);
    reset2_d    = (state_d == ST_COLD) || (state_d == ST_TRANSFER) || (state_d == ST_TRACK);
    cold_d      = (state_d == ST_COLD);
    lowbw_pre_d = (state_d == ST_TRANSFER) || (state_d == ST_TRACK);
    lowbw1_d    = (state_d == ST_TRACK);
    locked_d    = (state_d == ST_TRACK);
  end

  assign state                  = state_q;
  assign reset2                 = reset2_q;
  assign reset3                 = reset2_q;
  assign cold_start_traditional = cold_q;
  assign lowbw_pre              = lowbw_pre_q;
  assign lowbw1                 = lowbw1_q;
  assign fine_done_traditional  = fine_done_q;
  assign locked                 = locked_q;
  assign lock_lost              = lock_lost_q;

endmodule
